// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, parity helper and common keyboard command bytes.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      SHIFT,
      ACK,
      WAIT_IDLE
   } ps2_state_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] ACK_BYTE     = 8'hFA;

   // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-collector PS/2 line plus a falling-edge strobe.
module ps2_line_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic pin,
   output logic sync,
   output logic fall
);

   logic meta;
   logic prev;

   // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= pin;
         sync <= meta;
         prev <= sync;
      end
   end

   assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one byte clocked by the
// device, checks the device's ack bit, and reports done or error.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES     = 5000,
   parameter int unsigned START_SETUP_CYCLES = 50,
   parameter int unsigned TIMEOUT_CYCLES     = 750000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int unsigned CW =
      $clog2(max3(INHIBIT_CYCLES, START_SETUP_CYCLES, TIMEOUT_CYCLES) + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(START_SETUP_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   ps2_state_t    state;
   logic [CW-1:0] cnt;
   logic [3:0]    idx;
   logic [7:0]    byte_q;
   logic [9:0]    frame;
   logic          clk_sync;
   logic          clk_fall;
   logic          dat_sync;
   logic          dat_fall_unused;
   logic          timed_out;

   ps2_line_sync u_clk_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .pin     (ps2_clk_in),
      .sync    (clk_sync),
      .fall    (clk_fall)
   );

   ps2_line_sync u_dat_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .pin     (ps2_dat_in),
      .sync    (dat_sync),
      .fall    (dat_fall_unused)
   );

   // Bits shifted after the start bit: data LSB first, parity, then stop (released).
   assign frame     = {1'b1, odd_parity(byte_q), byte_q};
   assign timed_out = (cnt == TMO_LAST);
   assign tx_ready  = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         byte_q     <= '0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         tx_done    <= 1'b0;
         tx_error   <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  byte_q     <= tx_data;
                  cnt        <= '0;
                  ps2_clk_oe <= 1'b1;
                  ps2_dat_oe <= 1'b0;
                  state      <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (cnt == INH_LAST) begin
                  cnt        <= '0;
                  ps2_dat_oe <= 1'b1;
                  state      <= START;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            START: begin
               if (cnt == SET_LAST) begin
                  cnt        <= '0;
                  idx        <= '0;
                  ps2_clk_oe <= 1'b0;
                  state      <= SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               // Device-clocked phases share one timer; timeout beats a same-cycle clock fall.
               cnt <= cnt + 1'b1;
               if (timed_out) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  tx_error   <= 1'b1;
                  state      <= IDLE;
               end else begin
                  case (state)
                     SHIFT: begin
                        if (clk_fall) begin
                           ps2_dat_oe <= ~frame[idx];
                           idx        <= idx + 4'd1;
                           if (idx == 4'd9)
                              state <= ACK;
                        end
                     end
                     ACK: begin
                        if (clk_fall) begin
                           if (dat_sync) begin
                              tx_error <= 1'b1;
                              state    <= IDLE;
                           end else begin
                              state <= WAIT_IDLE;
                           end
                        end
                     end
                     WAIT_IDLE: begin
                        if (clk_sync && dat_sync) begin
                           tx_done <= 1'b1;
                           state   <= IDLE;
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural keyboard clocking the host frame.
module tb_ps2_host_tx;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       ps2_clk, ps2_dat;

   int total = 0;
   int passes = 0;
   int fails = 0;
   int clk_hi = 0, both_hi = 0, n_done = 0, n_err = 0, n_both = 0;

   assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES     (20),
      .START_SETUP_CYCLES (4),
      .TIMEOUT_CYCLES     (2000)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ps2_clk_in (ps2_clk),
      .ps2_dat_in (ps2_dat),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (ps2_clk_oe === 1'b1) clk_hi++;
      if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) both_hi++;
      if (tx_done === 1'b1) n_done++;
      if (tx_error === 1'b1) n_err++;
      if (tx_done === 1'b1 && tx_error === 1'b1) n_both++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit hold);
      int w;
      tx_data  = b;
      tx_valid = 1'b1;
      w = 0;
      tick;
      while (busy !== 1'b1 && w < 10) begin
         tick;
         w++;
      end
      check("accept", busy, 1);
      if (!hold) tx_valid = 1'b0;
   endtask

   // Keyboard side: samples data while clock is high, then pulses clock low.
   task automatic device(input int nfalls, input bit ack, output logic [10:0] bits);
      int w;
      bits = '0;
      w = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_dat === 1'b0) && w < 200) begin
         tick;
         w++;
      end
      check("start_seen", ps2_dat, 0);
      for (int i = 0; i < nfalls; i++) begin
         repeat (50) tick;
         bits[i] = ps2_dat;
         if (i == 10 && ack) dev_dat_low = 1'b1;
         dev_clk_low = 1'b1;
         repeat (50) tick;
         dev_clk_low = 1'b0;
      end
   endtask

   initial begin
      logic [10:0] bits;
      int c0, b0, d0, e0, n;

      repeat (3) tick;
      check("rst_tx_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_dat_oe", ps2_dat_oe, 0);
      check("rst_tx_done", tx_done, 0);
      check("rst_tx_error", tx_error, 0);
      reset_n = 1'b1;
      repeat (2) tick;

      // 0xED: inhibit/start timing, frame content, ack
      c0 = clk_hi; b0 = both_hi; d0 = n_done; e0 = n_err;
      send(8'hED, 1'b0);
      device(11, 1'b1, bits);
      dev_dat_low = 1'b0;
      repeat (10) tick;
      check("ed_clk_oe_cycles", clk_hi - c0, 24);
      check("ed_start_cycles", both_hi - b0, 4);
      check("ed_frame", {21'd0, bits}, {21'd0, 11'b1_1_11101101_0});
      check("ed_done", n_done - d0, 1);
      check("ed_no_err", n_err - e0, 0);
      check("ed_ready", tx_ready, 1);

      // 0x01 then 0x00 back to back: parity 0 then 1
      d0 = n_done;
      send(8'h01, 1'b0);
      device(11, 1'b1, bits);
      dev_dat_low = 1'b0;
      repeat (10) tick;
      check("b01_frame", {21'd0, bits}, {21'd0, 11'b1_0_00000001_0});
      check("b01_done", n_done - d0, 1);
      send(8'h00, 1'b0);
      device(11, 1'b1, bits);
      dev_dat_low = 1'b0;
      repeat (10) tick;
      check("b00_frame", {21'd0, bits}, {21'd0, 11'b1_1_00000000_0});
      check("b00_done", n_done - d0, 2);

      // NACK: data left high on the 11th clock
      d0 = n_done; e0 = n_err;
      send(8'hF0, 1'b0);
      device(11, 1'b0, bits);
      repeat (10) tick;
      check("nack_err", n_err - e0, 1);
      check("nack_no_done", n_done - d0, 0);
      check("nack_clk_oe", ps2_clk_oe, 0);
      check("nack_dat_oe", ps2_dat_oe, 0);
      check("nack_busy", busy, 0);

      // Timeout: device never clocks after release
      d0 = n_done; e0 = n_err;
      send(8'hAA, 1'b0);
      n = 0;
      while (ps2_clk_oe === 1'b1 && n < 100) begin
         tick;
         n++;
      end
      n = 0;
      while (tx_error !== 1'b1 && n < 3000) begin
         tick;
         n++;
      end
      check("tmo_cycles", n, 2000);
      check("tmo_clk_oe", ps2_clk_oe, 0);
      check("tmo_dat_oe", ps2_dat_oe, 0);
      tick;
      check("tmo_err_count", n_err - e0, 1);
      check("tmo_no_done", n_done - d0, 0);
      check("tmo_idle", tx_ready, 1);

      // tx_valid held during busy with a different byte
      d0 = n_done;
      send(8'hEE, 1'b1);
      tx_data = 8'h55;
      device(11, 1'b1, bits);
      tx_valid = 1'b0;
      dev_dat_low = 1'b0;
      repeat (10) tick;
      check("hold_frame", {21'd0, bits}, {21'd0, 11'b1_1_11101110_0});
      check("hold_done", n_done - d0, 1);
      check("hold_idle", busy, 0);

      // Reset after 4 device falls
      d0 = n_done; e0 = n_err;
      send(8'h10, 1'b0);
      device(4, 1'b1, bits);
      check("mid_dat_oe_pre", ps2_dat_oe, 1);
      reset_n = 1'b0;
      tick;
      check("mid_clk_oe", ps2_clk_oe, 0);
      check("mid_dat_oe", ps2_dat_oe, 0);
      check("mid_ready", tx_ready, 1);
      check("mid_no_done", tx_done, 0);
      check("mid_no_err", tx_error, 0);
      reset_n = 1'b1;
      repeat (20) tick;
      check("mid_pulses", (n_done - d0) + (n_err - e0), 0);

      // 0xFF after the reset
      d0 = n_done;
      send(8'hFF, 1'b0);
      device(11, 1'b1, bits);
      dev_dat_low = 1'b0;
      repeat (10) tick;
      check("ff_frame", {21'd0, bits}, {21'd0, 11'b1_1_11111111_0});
      check("ff_done", n_done - d0, 1);
      check("no_done_err_overlap", n_both, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
